// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl
//  Purpose  : Bit-serial (LSB first) WIDTH-bit adder sequencer driving a
//             single registered 1-bit full-adder slice, with start/busy/done
//             handshake, abort, and held result/carry/overflow outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] C_CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_CNT_MSB_IN = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic             carry_msb_q, carry_msb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    // Shared full-adder slice: sum bit and carry for the current bit position.
    logic w_s;
    logic w_carry;
    assign w_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign w_carry = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    // Next-state and datapath update; visible results only change on the last bit.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        carry_d     = carry_q;
        carry_msb_d = carry_msb_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    carry_d  = w_carry;
                    a_sh_d   = a_sh_q >> 1;
                    b_sh_d   = b_sh_q >> 1;
                    sum_sh_d = {w_s, sum_sh_q[WIDTH-1:1]};
                    cnt_d    = cnt_q + CW'(1);
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (cnt_q == C_CNT_MSB_IN) begin
                        carry_msb_d = w_carry;
                    end
                    if (cnt_q == C_CNT_LAST) begin
                        // Hold the counter so it never wraps within an operation.
                        cnt_d   = cnt_q;
                        sum_d   = {w_s, sum_sh_q[WIDTH-1:1]};
                        c_out_d = w_carry;
                        ovf_d   = carry_msb_q ^ w_carry;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            carry_msb_q <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            carry_q     <= carry_d;
            carry_msb_q <= carry_msb_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_ctrl
//  Purpose  : Self-checking bench for serial_add_ctrl (WIDTH=8): directed
//             vectors with hand-computed results plus a randomized sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int C_WIDTH = 8;

    logic               clk;
    logic               reset;
    logic               start;
    logic               abort;
    logic [C_WIDTH-1:0] a;
    logic [C_WIDTH-1:0] b;
    logic               c_in;
    logic               busy;
    logic               done;
    logic [C_WIDTH-1:0] sum;
    logic               c_out;
    logic               ovf;

    int n_tests  = 0;
    int n_failed = 0;
    int done_run = 0;
    int done_max = 0;

    serial_add_ctrl #(.WIDTH(C_WIDTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .abort (abort),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Track the longest run of consecutive cycles with done high.
    always @(negedge clk) begin
        if (done) begin
            done_run = done_run + 1;
            if (done_run > done_max) done_max = done_run;
        end else begin
            done_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Follow an accepted operation until busy drops (bounded).
    task automatic wait_op(output int nb, output int nd, output int dpos);
        nb = 0;
        nd = 0;
        dpos = -1;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            if (done) begin
                nd++;
                dpos = nb;
            end
            nb++;
            tick();
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tc, input logic [7:0] es, input logic ec, input logic eo);
        int nb, nd, dpos;
        a = ta; b = tb_v; c_in = tc; start = 1'b1;
        tick();
        start = 1'b0;
        wait_op(nb, nd, dpos);
        check({tag, ".busy_cycles"}, nb, 9);
        check({tag, ".done_count"}, nd, 1);
        check({tag, ".done_pos"}, dpos, 8);
        check({tag, ".sum"}, sum, es);
        check({tag, ".c_out"}, c_out, ec);
        check({tag, ".ovf"}, ovf, eo);
    endtask

    initial begin
        int nb, nd, dpos;
        int seen_done;
        logic [7:0] ra, rb, last_sum;
        logic       rc, last_cout;
        logic [8:0] exp_full;
        logic       exp_ovf;
        bit         do_abort;
        int         abort_at;

        reset = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0; c_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.sum", sum, 0);
        check("reset.c_out", c_out, 0);
        check("reset.ovf", ovf, 0);

        // Basic operations and overflow boundaries.
        run_op("t1_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("t2_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("t2_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Start held high through an operation: no restart, re-accepted after DONE.
        a = 8'hA5; b = 8'h5A; c_in = 1'b1; start = 1'b1;
        tick();
        a = 8'h01; b = 8'h01; c_in = 1'b0;
        wait_op(nb, nd, dpos);
        check("t3.busy_cycles", nb, 9);
        check("t3.done_count", nd, 1);
        check("t3.sum", sum, 8'h00);
        check("t3.c_out", c_out, 1);
        check("t3.ovf", ovf, 0);
        tick();
        start = 1'b0;
        check("t3.reaccept_busy", busy, 1);
        wait_op(nb, nd, dpos);
        check("t3.second_sum", sum, 8'h02);
        check("t3.second_done", nd, 1);

        // Reset in the middle of RUN discards the operation.
        a = 8'h33; b = 8'h11; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("t4.sum_held_in_run", sum, 8'h02);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4.busy", busy, 0);
        check("t4.done", done, 0);
        check("t4.sum", sum, 8'h00);
        check("t4.c_out", c_out, 0);
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) seen_done++;
            tick();
        end
        check("t4.no_done", seen_done, 0);
        run_op("t4_01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // Abort mid-RUN keeps the previous result.
        run_op("t5_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        a = 8'hF0; b = 8'h0F; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5.busy", busy, 0);
        check("t5.sum", sum, 8'h30);
        check("t5.done", done, 0);
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) seen_done++;
            tick();
        end
        check("t5.no_done", seen_done, 0);
        check("t5.sum_after", sum, 8'h30);

        // Randomized sweep with random aborts and ignored mid-run starts.
        last_sum = sum;
        last_cout = c_out;
        for (int op = 0; op < 1000; op++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            do_abort = ($urandom_range(0, 3) == 0);
            abort_at = int'($urandom_range(1, 8));
            a = ra; b = rb; c_in = rc; start = 1'b1;
            tick();
            start = 1'b0;
            nd = 0;
            for (int k = 1; k <= 20; k++) begin
                if (!busy) break;
                if (done) nd++;
                start = 1'($urandom);
                a = 8'($urandom);
                b = 8'($urandom);
                abort = do_abort && (k == abort_at);
                tick();
            end
            start = 1'b0;
            abort = 1'b0;
            check("rnd.idle_after", busy, 0);
            if (do_abort) begin
                check("rnd.abort_no_done", nd, 0);
                check("rnd.abort_sum_held", {c_out, sum}, {last_cout, last_sum});
            end else begin
                exp_full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
                exp_ovf  = (ra[7] == rb[7]) && (exp_full[7] != ra[7]);
                check("rnd.done", nd, 1);
                check("rnd.result", {c_out, sum}, exp_full);
                check("rnd.ovf", ovf, exp_ovf);
                last_sum = exp_full[7:0];
                last_cout = exp_full[8];
            end
        end
        check("rnd.done_max_width", done_max, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
`default_nettype wire
